// File: rtl/itch_pkg.sv
// itch_pkg: ITCH type bytes, action codes, the queued message record and the type decoder
package itch_pkg;
  localparam logic [7:0] TYPE_ADD = 8'h41;
  localparam logic [7:0] TYPE_EXEC = 8'h45;
  localparam logic [7:0] TYPE_CANCEL = 8'h58;
  localparam logic [7:0] TYPE_DELETE = 8'h44;
  localparam logic [2:0] ACTION_NONE = 3'd0;
  localparam logic [2:0] ACTION_ADD = 3'd1;
  localparam logic [2:0] ACTION_EXEC = 3'd2;
  localparam logic [2:0] ACTION_CANCEL = 3'd3;
  localparam logic [2:0] ACTION_DELETE = 3'd4;
  localparam int TS_MAX_W = 64;
  typedef struct packed {
    logic [2:0] action;
    logic [31:0] symbol;
    logic [31:0] field;
    logic [TS_MAX_W-1:0] ts;
  } msg_t;
  function automatic logic [2:0] decode_type(input logic [7:0] t);
    return t == TYPE_ADD ? ACTION_ADD :
           t == TYPE_EXEC ? ACTION_EXEC :
           t == TYPE_CANCEL ? ACTION_CANCEL :
           t == TYPE_DELETE ? ACTION_DELETE : ACTION_NONE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; clk/rst_n, push+wdata in, pop+rdata out (show-ahead), full/empty/count status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic [WIDTH-1:0] wdata,
  input  logic pop,
  output logic [WIDTH-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_comb begin
    wr_d = push ? wr_q + ONE : wr_q;
    rd_d = pop ? rd_q + ONE : rd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
  assign rdata = mem_q[rd_q[AW-1:0]];
  assign count = wr_q - rd_q;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/itch_multichannel_parser.sv
// itch_multichannel_parser: per-lane ITCH decode+timestamp into lane FIFOs, round-robin merge into a registered valid/ready stream; in_* lanes, out_* merged update, pkt/err saturating counters, fifo_level per lane
module itch_multichannel_parser
  import itch_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH*8-1:0] in_type,
  output logic [NUM_CH-1:0] in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  output logic [2:0] out_action,
  output logic [31:0] out_symbol,
  output logic [31:0] out_field,
  output logic [TS_WIDTH-1:0] out_ts,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0] fifo_level
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int MW = $bits(msg_t);
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d, err_q, err_d;
  logic [CNT_WIDTH:0] pkt_sum, err_sum;
  logic rdy_q, rdy_d;
  logic [CW-1:0] rr_q, rr_d, grant, idx, out_ch_q, out_ch_d;
  logic [CW:0] idx_sum;
  logic found, load, out_valid_q, out_valid_d;
  msg_t out_q, out_d;
  logic [NUM_CH-1:0] full, empty, push, pop, known;
  logic [2:0] act [NUM_CH];
  logic [MW-1:0] rdata [NUM_CH];
  msg_t wmsg [NUM_CH];
  logic [LW-1:0] level [NUM_CH];
  assign in_ready = ~full & {NUM_CH{rdy_q}};
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign act[i] = decode_type(in_type[i*8 +: 8]);
    assign known[i] = act[i] != ACTION_NONE;
    assign push[i] = in_valid[i] && in_ready[i] && known[i];
    assign wmsg[i] = '{action: act[i], symbol: in_data[i*DATA_WIDTH+32 +: 32],
                       field: in_data[i*DATA_WIDTH +: 32], ts: TS_MAX_W'(ts_q)};
    assign fifo_level[i*LW +: LW] = level[i];
    sync_fifo #(.WIDTH(MW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push[i]), .wdata(wmsg[i]), .pop(pop[i]),
      .rdata(rdata[i]), .full(full[i]), .empty(empty[i]), .count(level[i])
    );
  end
  always_comb begin
    ts_d = ts_q + TS_WIDTH'(1);
    rdy_d = 1'b1;
    pkt_sum = {1'b0, pkt_q};
    err_sum = {1'b0, err_q};
    for (int i = 0; i < NUM_CH; i++) begin
      pkt_sum = pkt_sum + (CNT_WIDTH+1)'(push[i]);
      err_sum = err_sum + (CNT_WIDTH+1)'(in_valid[i] && in_ready[i] && !known[i]);
    end
    pkt_d = pkt_sum[CNT_WIDTH] ? '1 : pkt_sum[CNT_WIDTH-1:0];
    err_d = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
  end
  // Scan offsets from the far end so the nearest non-empty lane after rr_q wins.
  always_comb begin
    found = 1'b0;
    grant = rr_q;
    idx_sum = '0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_q} + (CW+1)'(k);
      idx = idx_sum >= (CW+1)'(NUM_CH) ? CW'(idx_sum - (CW+1)'(NUM_CH)) : CW'(idx_sum);
      if (!empty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    load = !out_valid_q || out_ready;
    pop = '0;
    if (load && found) pop[grant] = 1'b1;
    rr_d = (load && found) ? (grant == CW'(NUM_CH - 1) ? '0 : grant + CW'(1)) : rr_q;
    out_valid_d = load ? found : out_valid_q;
    out_d = (load && found) ? msg_t'(rdata[grant]) : out_q;
    out_ch_d = (load && found) ? grant : out_ch_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
      pkt_q <= '0;
      err_q <= '0;
      rdy_q <= 1'b0;
      rr_q <= '0;
      out_valid_q <= 1'b0;
      out_ch_q <= '0;
      out_q <= '0;
    end else begin
      ts_q <= ts_d;
      pkt_q <= pkt_d;
      err_q <= err_d;
      rdy_q <= rdy_d;
      rr_q <= rr_d;
      out_valid_q <= out_valid_d;
      out_ch_q <= out_ch_d;
      out_q <= out_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_ch = out_ch_q;
  assign out_action = out_q.action;
  assign out_symbol = out_q.symbol;
  assign out_field = out_q.field;
  assign out_ts = out_q.ts[TS_WIDTH-1:0];
  assign pkt_count = pkt_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_itch_multichannel_parser.sv
// tb_itch_multichannel_parser: queue-based reference model and scoreboard for the merged ITCH parser
module tb_itch_multichannel_parser;
  localparam int NCH = 4;
  localparam int DEPTH = 16;
  localparam int LW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH*64-1:0] in_data = '0;
  logic [NCH*8-1:0] in_type = '0;
  logic [NCH-1:0] in_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [1:0] out_ch;
  logic [2:0] out_action;
  logic [31:0] out_symbol, out_field;
  logic [63:0] out_ts;
  logic [31:0] pkt_count, err_count;
  logic [NCH*LW-1:0] fifo_level;
  always #5 clk = ~clk;
  itch_multichannel_parser dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_type(in_type),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_action(out_action), .out_symbol(out_symbol), .out_field(out_field), .out_ts(out_ts),
    .pkt_count(pkt_count), .err_count(err_count), .fifo_level(fifo_level)
  );
  typedef struct {
    int ch;
    logic [2:0] act;
    logic [31:0] sym;
    logic [31:0] fld;
    logic [63:0] ts;
  } item_t;
  item_t lane_q[NCH][$];
  item_t exp_q[$];
  bit busy, started, done;
  int rr;
  logic [63:0] cyc;
  logic [63:0] last_ts [NCH];
  logic [31:0] m_pkt, m_err;
  int n_chk, n_pass;
  function automatic logic [2:0] ref_action(input logic [7:0] t);
    case (t)
      8'h41: return 3'd1;
      8'h45: return 3'd2;
      8'h58: return 3'd3;
      8'h44: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return v == 32'hFFFF_FFFF ? v : v + 32'd1;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      lane_q[i].delete();
      last_ts[i] = '0;
    end
    exp_q.delete();
    busy = 0;
    started = 0;
    rr = 0;
    cyc = '0;
    m_pkt = '0;
    m_err = '0;
  endtask
  // One rising edge: drain/grant uses queue contents from before the edge, then accepted input is queued.
  task automatic model_edge();
    bit [NCH-1:0] rdy;
    int g;
    item_t it;
    logic [2:0] a;
    for (int i = 0; i < NCH; i++) rdy[i] = started && lane_q[i].size() < DEPTH;
    if (busy && out_ready) busy = 0;
    if (!busy) begin
      g = -1;
      for (int k = 0; k < NCH; k++)
        if (g < 0 && lane_q[(rr + k) % NCH].size() > 0) g = (rr + k) % NCH;
      if (g >= 0) begin
        exp_q.push_back(lane_q[g].pop_front());
        busy = 1;
        rr = (g + 1) % NCH;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (in_valid[i] && rdy[i]) begin
        a = ref_action(in_type[i*8 +: 8]);
        if (a != 3'd0) begin
          it.ch = i;
          it.act = a;
          it.sym = in_data[i*64+32 +: 32];
          it.fld = in_data[i*64 +: 32];
          it.ts = cyc;
          lane_q[i].push_back(it);
          m_pkt = sat_inc(m_pkt);
        end else m_err = sat_inc(m_err);
      end
    end
    cyc = cyc + 64'd1;
    started = 1;
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask
  task automatic drive(input int lane, input logic [7:0] t, input logic [63:0] d);
    in_valid[lane] = 1'b1;
    in_type[lane*8 +: 8] = t;
    in_data[lane*64 +: 64] = d;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_levels", fifo_level, 0);
    chk("rst_out_data", {out_action, out_symbol, out_field}, 0);
    chk("rst_out_ts", out_ts, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask
  task automatic drain();
    int guard;
    bit idle;
    out_ready = 1'b1;
    in_valid = '0;
    guard = 0;
    idle = 0;
    while (!idle && guard < 300) begin
      tick();
      guard++;
      idle = !busy && exp_q.size() == 0;
      for (int i = 0; i < NCH; i++) if (lane_q[i].size() != 0) idle = 0;
    end
    if (!idle) begin
      n_chk++;
      $display("FAIL drain_timeout: queued=%0d busy=%0d", exp_q.size(), busy);
    end
  endtask
  // Monitor: status every cycle; the held output is compared to the scoreboard front, popped on transfer.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      chk("out_valid", out_valid, busy);
      chk("pkt_count", pkt_count, m_pkt);
      chk("err_count", err_count, m_err);
      for (int i = 0; i < NCH; i++) begin
        chk("in_ready", in_ready[i], started && lane_q[i].size() < DEPTH);
        chk("fifo_level", fifo_level[i*LW +: LW], lane_q[i].size());
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL out_unexpected: got ch=%0d sym=%0h expected no output", out_ch, out_symbol);
        end else begin
          e = exp_q[0];
          chk("out_ch", out_ch, e.ch);
          chk("out_action", out_action, e.act);
          chk("out_symbol", out_symbol, e.sym);
          chk("out_field", out_field, e.fld);
          chk("out_ts", out_ts, e.ts);
          if (out_ready) begin
            chk("ts_order", out_ts > last_ts[out_ch], 1);
            last_ts[out_ch] = out_ts;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end
  initial begin
    int base, guard;
    logic [7:0] t;
    model_reset();
    do_reset();
    out_ready = 1'b1;
    drive(0, 8'h41, 64'h41415054_64000000);
    tick();
    in_valid = '0;
    tick();
    chk("first_out_valid", out_valid, 1);
    chk("first_symbol", out_symbol, 32'h41415054);
    drain();
    repeat (2) begin
      for (int i = 0; i < NCH; i++) drive(i, 8'h45, {32'h5359_4D00 + 32'(i), 32'(i * 100)});
      tick();
      in_valid = '0;
      drain();
    end
    drive(2, 8'hFF, 64'h1);
    tick();
    drive(2, 8'h58, 64'h43414E43_00000007);
    tick();
    in_valid = '0;
    drain();
    out_ready = 1'b0;
    base = int'(m_pkt);
    guard = 0;
    while (int'(m_pkt) - base < 17 && guard < 60) begin
      drive(1, 8'h41, {32'h4C4E3100, 32'(guard)});
      tick();
      guard++;
    end
    in_valid = '0;
    repeat (5) tick();
    chk("full_in_ready", in_ready[1], 0);
    chk("full_level", fifo_level[1*LW +: LW], 16);
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 8'h44, {32'h52535400, 32'(i)});
    tick();
    in_valid = '0;
    tick();
    do_reset();
    repeat (5) tick();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        case ($urandom_range(0, 4))
          0: t = 8'h41;
          1: t = 8'h45;
          2: t = 8'h58;
          3: t = 8'h44;
          default: t = 8'($urandom_range(0, 255));
        endcase
        in_valid[i] = $urandom_range(0, 2) == 0;
        in_type[i*8 +: 8] = t;
        in_data[i*64 +: 64] = {32'($urandom), 32'($urandom)};
      end
      out_ready = (c % 400) < 300 ? $urandom_range(0, 3) != 0 : 1'b0;
      tick();
    end
    drain();
    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/itch_multichannel_parser.md
Name: itch_multichannel_parser

Overview:
- Next-generation market data front end: NUM_CH independent ITCH feed lanes, each with its own ingress FIFO.
- Messages are decoded and timestamped at ingress.
- A round-robin arbiter merges lanes into one registered valid/ready update stream feeding the order book.
- Replaces the single-lane processor; adds multi-channel merge, backpressure, per-message timestamps and saturating statistics.

Parameters:
- NUM_CH, 4, number of feed lanes (1..8)
- DATA_WIDTH, 64, message payload width; [63:32] symbol, [31:0] price/volume field
- FIFO_DEPTH, 16, entries per lane FIFO (power of two, >=2)
- TS_WIDTH, 64, free-running timestamp counter width
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_CH  per-lane message valid
- in_data  in  NUM_CH*DATA_WIDTH  lane i payload at [i*DATA_WIDTH +: DATA_WIDTH]
- in_type  in  NUM_CH*8  lane i ITCH type byte at [i*8 +: 8]
- in_ready  out  NUM_CH  per-lane ready (FIFO not full)
- out_valid  out  1  merged update valid
- out_ready  in  1  downstream accept
- out_ch  out  $clog2(NUM_CH) (min 1)  source lane
- out_action  out  3  1=ADD('A'), 2=EXEC('E'), 3=CANCEL('X'), 4=DELETE('D')
- out_symbol  out  32  symbol
- out_field  out  32  price/volume field
- out_ts  out  TS_WIDTH  timestamp captured at ingress
- pkt_count  out  CNT_WIDTH  valid messages accepted
- err_count  out  CNT_WIDTH  unknown-type messages discarded
- fifo_level  out  NUM_CH*($clog2(FIFO_DEPTH)+1)  per-lane occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0; all out_* data=0; counters, timestamp, FIFO pointers and levels=0; arbiter pointer=lane 0; in_ready=all 1s one cycle after reset release.
- Reset mid-operation: all FIFO contents and any held output are discarded immediately.
- Timestamp: ts increments every cycle and wraps at 2^TS_WIDTH.
- Ingress handshake: transfer on lane i when in_valid[i]&&in_ready[i] at a rising edge; in_ready[i]=!full[i], registered-free.
- Ingress decode:
  - Types 'A'(0x41), 'E'(0x45), 'X'(0x58), 'D'(0x44) write {action, payload, ts} into the lane FIFO; pkt_count += 1 per lane.
  - Any other type: accepted (consumes handshake), not stored; err_count += 1 per lane.
  - Simultaneous events: counters add the number of lanes in that class this cycle. Counters saturate at all-ones.
- Arbiter:
  - Each cycle the output register is empty or being drained (out_valid&&out_ready), grant the first non-empty lane at or after rr_ptr (cyclic); pop it and load the output register.
  - rr_ptr <= grant+1 mod NUM_CH. No grant leaves rr_ptr unchanged.
- Latency: message accepted at edge k with an empty pipeline gives out_valid high after edge k+1. Minimum 1 cycle; same-cycle bypass is forbidden.
- Output: out_* held stable while out_valid&&!out_ready. Sustained throughput is one message per cycle when out_ready=1.
- Full boundary: a FIFO with FIFO_DEPTH entries drops in_ready. A simultaneous pop and push on a full lane is allowed only if the pop is registered first; in_ready stays low that cycle (conservative, no combinational ready path).
- Empty boundary: empty lanes are never granted.
- Pointer wrap: FIFO pointers carry one extra wrap bit.
- fifo_level: updated the same edge as push/pop; simultaneous push and pop leaves the level unchanged.

Decomposition:
- Package itch_pkg: ITCH type byte constants, ACTION_* encodings, and a message struct typedef {action, symbol, field, ts}.
- Sub-module sync_fifo (parametrised width and depth; count output), instantiated NUM_CH times via generate.
- Decode, arbiter and output register stay in the top module.

Test Plan:
- Lane 0 sends type 0x41, data {0x41415054, 0x64000000}; out_ready=1 -> one cycle later out_valid=1, out_ch=0, out_action=1, out_symbol=0x41415054, out_field=0x64000000; pkt_count=1.
- All 4 lanes send 0x45 in the same cycle, out_ready=1 -> four outputs on consecutive cycles, out_ch order 0,1,2,3; next same-cycle burst is granted starting at lane 0 after wrap.
- Lane 2 sends type 0xFF, then 0x58 -> err_count=1, pkt_count=1; single output with out_action=3, out_ch=2.
- out_ready=0, lane 1 streams 17 messages of type 0x41 -> 16 stored plus 1 held in the output register; in_ready[1]=0 and fifo_level lane 1=16 thereafter. Release out_ready -> 17 outputs in order, out_ts strictly increasing.
- out_valid high with out_ready=0 for 5 cycles -> out_* unchanged every cycle.
- Reset asserted mid-burst with 3 queued messages -> out_valid=0 and all levels 0 immediately; after release, no stale output.
